gps_ack_peak_sel: RTL

- Sits directly downstream of the gps_ack2 acquisition correlator.
- On every corr_complete it captures the 8 parallel channel results (sat ID, I/Q integrators) with the current code_phase, code_nco_frac and doppler_omega.
- Drains the 8 channels one per cycle, computes magnitude and keeps the per-channel peak over the whole search.
- On search_complete it flags detection per channel against a threshold and exposes results through an indexed read port.

---
 rtl/gps_ack_peak_sel.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/gps_ack_peak_sel.sv
// rtl/gps_ack_peak_sel.sv - per-channel peak picker behind the gps_ack2 acquisition correlator
// Captures 8 channel results per corr_complete, drains one channel per cycle into a peak table.
module gps_ack_peak_sel #(
  parameter int          NCH    = 8,
  parameter logic [14:0] THRESH = 15'd1200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ack_start,
  input  logic        corr_complete,
  input  logic        search_complete,
  input  logic [5:0]  sat0, sat1, sat2, sat3, sat4, sat5, sat6, sat7,
  input  logic [13:0] integrator_i0, integrator_i1, integrator_i2, integrator_i3,
  input  logic [13:0] integrator_i4, integrator_i5, integrator_i6, integrator_i7,
  input  logic [13:0] integrator_q0, integrator_q1, integrator_q2, integrator_q3,
  input  logic [13:0] integrator_q4, integrator_q5, integrator_q6, integrator_q7,
  input  logic [9:0]  code_phase,
  input  logic [4:0]  code_nco_frac,
  input  logic [15:0] doppler_omega,
  input  logic [2:0]  rd_sel,
  output logic        busy,
  output logic        result_valid,
  output logic        overrun,
  output logic [7:0]  det_mask,
  output logic [5:0]  rd_sat,
  output logic [14:0] rd_mag,
  output logic [9:0]  rd_code_phase,
  output logic [4:0]  rd_code_frac,
  output logic [15:0] rd_doppler
);

  typedef enum logic [1:0] {IDLE, DRAIN, FINAL} state_t;
  state_t state, state_nxt;

  logic [2:0]  ch;
  logic        pending;

  logic [5:0]  in_sat [NCH];
  logic [13:0] in_i   [NCH];
  logic [13:0] in_q   [NCH];

  logic [5:0]  cap_sat [NCH];
  logic [13:0] cap_i   [NCH];
  logic [13:0] cap_q   [NCH];
  logic [9:0]  cap_phase;
  logic [4:0]  cap_frac;
  logic [15:0] cap_dop;

  logic [14:0] tab_mag   [NCH];
  logic [9:0]  tab_phase [NCH];
  logic [4:0]  tab_frac  [NCH];
  logic [15:0] tab_dop   [NCH];
  logic [5:0]  tab_sat   [NCH];

  logic [13:0] abs_i, abs_q;
  logic [14:0] cur_mag;
  logic        capture;

  assign in_sat = '{sat0, sat1, sat2, sat3, sat4, sat5, sat6, sat7};
  assign in_i   = '{integrator_i0, integrator_i1, integrator_i2, integrator_i3,
                    integrator_i4, integrator_i5, integrator_i6, integrator_i7};
  assign in_q   = '{integrator_q0, integrator_q1, integrator_q2, integrator_q3,
                    integrator_q4, integrator_q5, integrator_q6, integrator_q7};

  // Negating -8192 in 14 bits yields 14'h2000, which reads as +8192 unsigned.
  always_comb begin
    abs_i   = cap_i[ch][13] ? (~cap_i[ch] + 14'd1) : cap_i[ch];
    abs_q   = cap_q[ch][13] ? (~cap_q[ch] + 14'd1) : cap_q[ch];
    cur_mag = {1'b0, abs_i} + {1'b0, abs_q};
  end

  assign capture = (state == IDLE) && corr_complete && !ack_start;
  assign busy    = (state == DRAIN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (corr_complete) state_nxt = DRAIN;
               else if (search_complete) state_nxt = FINAL;
      DRAIN:   if (ch == 3'd7) state_nxt = (pending || search_complete) ? FINAL : IDLE;
      FINAL:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (ack_start) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      cap_sat   <= in_sat;
      cap_i     <= in_i;
      cap_q     <= in_q;
      cap_phase <= code_phase;
      cap_frac  <= code_nco_frac;
      cap_dop   <= doppler_omega;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || ack_start) begin
      ch           <= 3'd0;
      pending      <= 1'b0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
      det_mask     <= 8'd0;
      for (int k = 0; k < NCH; k++) begin
        tab_mag[k]   <= '0;
        tab_phase[k] <= '0;
        tab_frac[k]  <= '0;
        tab_dop[k]   <= '0;
        tab_sat[k]   <= '0;
      end
    end else begin
      if (corr_complete && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          ch      <= 3'd0;
          pending <= corr_complete & search_complete;
        end
        DRAIN: begin
          ch      <= ch + 3'd1;
          pending <= pending | search_complete;
          // Strict compare: ties keep the earlier peak.
          if (cur_mag > tab_mag[ch]) begin
            tab_mag[ch]   <= cur_mag;
            tab_phase[ch] <= cap_phase;
            tab_frac[ch]  <= cap_frac;
            tab_dop[ch]   <= cap_dop;
            tab_sat[ch]   <= cap_sat[ch];
          end
        end
        FINAL: begin
          pending      <= 1'b0;
          result_valid <= 1'b1;
          for (int k = 0; k < NCH; k++) det_mask[k] <= (tab_mag[k] >= THRESH);
        end
        default: pending <= 1'b0;
      endcase
    end
  end

  assign rd_sat        = tab_sat[rd_sel];
  assign rd_mag        = tab_mag[rd_sel];
  assign rd_code_phase = tab_phase[rd_sel];
  assign rd_code_frac  = tab_frac[rd_sel];
  assign rd_doppler    = tab_dop[rd_sel];

endmodule
